// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// instruction-format constants.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_BR,
        PC_SEL_J,
        PC_SEL_JR
    } pc_sel_e;

    localparam int unsigned INSN_BYTES   = 4;
    localparam int unsigned JUMP_HI_BITS = 4;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack. It is a circular buffer, so a push into a full stack
// overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_data,
    output logic [ADDR_W-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en;

    assign full  = (count_q == CW'(RAS_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // ptr_q names the next free slot; the top entry sits one below it
    assign top   = empty ? '0 : mem_q[ptr_q - PW'(1)];

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (pop && !empty) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end else if (push && !pop) begin
            wr_en   = 1'b1;
            ptr_d   = ptr_q + PW'(1);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, branch/jump/jr target selection,
// return-address stack bookkeeping, return-mismatch counter and alignment fault.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int unsigned       RAS_DEPTH  = 4,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          stall,
    input  logic [ADDR_W-1:0]             imm,
    input  logic                          branch,
    input  logic                          zero,
    input  logic                          jump,
    input  logic                          jal,
    input  logic                          jr,
    input  logic                          ret,
    input  logic [ADDR_W-1:0]             rs_value,
    output logic [ADDR_W-1:0]             pc_out,
    output logic [ADDR_W-1:0]             pc_plus4,
    output logic [ADDR_W-1:0]             next_pc,
    output logic                          taken,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic [ADDR_W-1:0]             ras_top,
    output logic [CNT_W-1:0]              mismatch_cnt,
    output logic                          align_fault
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  mismatch_q, mismatch_d;
    logic              align_q, align_d;

    logic [ADDR_W-1:0] br_target, j_target, jr_target;
    pc_sel_e           sel;
    logic              ras_push, ras_pop, ras_full, ras_empty;

    assign pc_plus4  = pc_q + ADDR_W'(INSN_BYTES);
    assign br_target = pc_plus4 + (imm << 2);
    assign j_target  = {pc_plus4[ADDR_W-1 -: JUMP_HI_BITS],
                        imm[ADDR_W-JUMP_HI_BITS-3:0], 2'b00};
    assign jr_target = {rs_value[ADDR_W-1:2], 2'b00};

    always_comb begin
        sel = PC_SEL_SEQ;
        if (jr) begin
            sel = PC_SEL_JR;
        end else if (jump || jal) begin
            sel = PC_SEL_J;
        end else if (branch && zero) begin
            sel = PC_SEL_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            PC_SEL_BR: next_pc = br_target;
            PC_SEL_J:  next_pc = j_target;
            PC_SEL_JR: next_pc = jr_target;
            default:   next_pc = pc_plus4;
        endcase
    end

    assign taken    = (sel != PC_SEL_SEQ);
    assign ras_push = !stall && jal && !jr;
    assign ras_pop  = !stall && jr && ret;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_comb begin
        pc_d       = stall ? pc_q : next_pc;
        mismatch_d = mismatch_q;
        align_d    = align_q;
        // a return with an empty stack counts as a misprediction too
        if (ras_pop && (ras_empty || ras_top != jr_target) && mismatch_q != '1) begin
            mismatch_d = mismatch_q + CNT_W'(1);
        end
        if (!stall && jr && rs_value[1:0] != 2'b00) begin
            align_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q       <= RESET_ADDR;
            mismatch_q <= '0;
            align_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mismatch_q <= mismatch_d;
            align_q    <= align_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (!ras_full || ras_count == ($clog2(RAS_DEPTH) + 1)'(RAS_DEPTH));
        end
    end

    assign pc_out       = pc_q;
    assign mismatch_cnt = mismatch_q;
    assign align_fault  = align_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        stall, branch, zero, jump, jal, jr, ret;
    logic [31:0] imm, rs_value;
    logic [31:0] pc_out, pc_plus4, next_pc, ras_top;
    logic        taken, align_fault;
    logic [2:0]  ras_count;
    logic [15:0] mismatch_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_sequencer #(
        .ADDR_W     (32),
        .RESET_ADDR (32'h0),
        .RAS_DEPTH  (4),
        .CNT_W      (16)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .stall        (stall),
        .imm          (imm),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .jal          (jal),
        .jr           (jr),
        .ret          (ret),
        .rs_value     (rs_value),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .taken        (taken),
        .ras_count    (ras_count),
        .ras_top      (ras_top),
        .mismatch_cnt (mismatch_cnt),
        .align_fault  (align_fault)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; zero = 0; jump = 0; jal = 0; jr = 0; ret = 0;
        imm = '0; rs_value = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        #7;
        @(negedge CLK);
        RST_N = 1;
        #1;
    endtask

    logic [31:0] jal_imm [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    logic [31:0] jal_pc  [5] = '{32'h40, 32'h80, 32'hC0, 32'h100, 32'h140};
    logic [31:0] ret_rs  [5] = '{32'h104, 32'hC4, 32'h84, 32'h44, 32'h4};
    logic [2:0]  ret_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic [15:0] ret_mis [5] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1};

    initial begin
        do_reset();
        check("rst_pc", pc_out, 32'h0);
        check("rst_cnt", ras_count, 3'd0);
        check("rst_top", ras_top, 32'h0);
        check("rst_mis", mismatch_cnt, 16'd0);
        check("rst_align", align_fault, 1'b0);
        check("rst_plus4", pc_plus4, 32'h4);
        check("rst_next", next_pc, 32'h4);
        check("rst_taken", taken, 1'b0);
        step(); check("seq_pc1", pc_out, 32'h4);
        step(); check("seq_pc2", pc_out, 32'h8);
        step(); check("seq_pc3", pc_out, 32'hC);

        // branch at 0x100
        jr = 1; rs_value = 32'h100;
        #1 check("jr_taken", taken, 1'b1);
        step(); check("jr_pc", pc_out, 32'h100);
        check("jr_noret_cnt", ras_count, 3'd0);
        jr = 0; branch = 1; zero = 1; imm = 32'hFFFF_FFFE;
        #1 check("br_next", next_pc, 32'hFC);
        check("br_taken", taken, 1'b1);
        zero = 0;
        #1 check("br_nt_next", next_pc, 32'h104);
        check("br_nt_taken", taken, 1'b0);
        step(); check("br_nt_pc", pc_out, 32'h104);

        // call/return in the upper region
        idle_inputs(); jr = 1; rs_value = 32'h4000_0010;
        step(); check("hi_pc", pc_out, 32'h4000_0010);
        idle_inputs(); jal = 1; imm = 32'h40;
        step(); check("jal_pc", pc_out, 32'h4000_0100);
        check("jal_cnt", ras_count, 3'd1);
        check("jal_top", ras_top, 32'h4000_0014);
        idle_inputs(); jr = 1; ret = 1; rs_value = 32'h4000_0014;
        step(); check("ret_pc", pc_out, 32'h4000_0014);
        check("ret_cnt", ras_count, 3'd0);
        check("ret_mis", mismatch_cnt, 16'd0);
        check("ret_top", ras_top, 32'h0);

        // RAS overflow then underflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs(); jal = 1; imm = jal_imm[i];
            step(); check($sformatf("ovf_pc%0d", i), pc_out, jal_pc[i]);
        end
        check("ovf_cnt", ras_count, 3'd4);
        check("ovf_top", ras_top, 32'h104);
        for (int i = 0; i < 5; i++) begin
            idle_inputs(); jr = 1; ret = 1; rs_value = ret_rs[i];
            step();
            check($sformatf("unf_pc%0d", i), pc_out, ret_rs[i]);
            check($sformatf("unf_cnt%0d", i), ras_count, ret_cnt[i]);
            check($sformatf("unf_mis%0d", i), mismatch_cnt, ret_mis[i]);
        end
        // mispredicted return with a non-empty stack
        idle_inputs(); jal = 1; imm = 32'h20;
        step(); check("mp_pc", pc_out, 32'h80);
        check("mp_top", ras_top, 32'h8);
        idle_inputs(); jr = 1; ret = 1; jal = 1; rs_value = 32'h10C;
        step(); check("mp_ret_pc", pc_out, 32'h10C);
        check("mp_cnt", ras_count, 3'd0);
        check("mp_mis", mismatch_cnt, 16'd2);

        // misaligned jr
        idle_inputs(); jr = 1; rs_value = 32'h203;
        step(); check("al_pc", pc_out, 32'h200);
        check("al_fault", align_fault, 1'b1);
        idle_inputs();
        step(); step();
        check("al_sticky", align_fault, 1'b1);
        check("al_seq_pc", pc_out, 32'h208);

        // stall while jal
        stall = 1; jal = 1; imm = 32'h100;
        #1 check("st_next", next_pc, 32'h400);
        check("st_taken", taken, 1'b1);
        step(); check("st_pc", pc_out, 32'h208);
        check("st_cnt", ras_count, 3'd0);
        stall = 0;
        step(); check("st_go_pc", pc_out, 32'h400);
        check("st_go_cnt", ras_count, 3'd1);
        check("st_go_top", ras_top, 32'h20C);

        // asynchronous reset mid-cycle
        idle_inputs();
        @(posedge CLK);
        #2 RST_N = 0;
        #1;
        check("ar_pc", pc_out, 32'h0);
        check("ar_cnt", ras_count, 3'd0);
        check("ar_top", ras_top, 32'h0);
        check("ar_mis", mismatch_cnt, 16'd0);
        check("ar_align", align_fault, 1'b0);
        @(negedge CLK);
        RST_N = 1;
        step(); check("ar_first_pc", pc_out, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
